// File: rtl/chroni_line_fetch.sv
// Text-mode line builder: fetches character codes and font bytes, expands them into the back
// bank of a double-buffered line RAM and streams the front bank. Option: CHRONI_LINE_FETCH_ATTR_EN.
module chroni_line_fetch #(
    parameter int COLS   = 40,
    parameter int FONT_H = 8,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 16,
    localparam int FS_W  = $clog2(FONT_H)
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic              line_start,
    input  logic [ADDR_W-1:0] text_addr,
    input  logic [ADDR_W-1:0] font_base,
    input  logic [FS_W-1:0]   font_scan,
    input  logic [PIX_W-1:0]  fg_color,
    input  logic [PIX_W-1:0]  bg_color,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_req,
    input  logic              mem_rd_ack,
    input  logic [7:0]        mem_data,
    input  logic [9:0]        pix_idx,
    output logic [PIX_W-1:0]  pix_out,
    output logic              busy,
    output logic              overrun
);
    localparam int LINE_PIX = COLS * 8;
    localparam int BUF_AW   = $clog2(2 * LINE_PIX);
    localparam int COL_W    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [BUF_AW-1:0] LINE_PIX_B = BUF_AW'(LINE_PIX);
    localparam logic [10:0]       LINE_PIX_I = 11'(LINE_PIX);
    localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(COLS - 1);
`ifdef CHRONI_LINE_FETCH_ATTR_EN
    localparam logic [ADDR_W-1:0] ATTR_OFFSET = ADDR_W'(16'h0800);
`endif

    typedef enum logic [2:0] {S_IDLE, S_CHAR, S_ATTR, S_FONT, S_SHIFT} state_t;

    state_t              state_r, state_s;
    logic                req_r, req_s, busy_r, busy_s, overrun_r, overrun_s, front_r, front_s;
    logic [ADDR_W-1:0]   addr_r, addr_s, text_r, font_r;
    logic [COL_W-1:0]    col_r, col_s;
    logic [2:0]          bit_r, bit_s;
    logic [7:0]          code_r, code_s, byte_r, byte_s;
    logic [FS_W-1:0]     scan_r;
    logic [PIX_W-1:0]    fg_r, bg_r, fg_cur_s, bg_cur_s, wr_data_s;
    logic                wr_en_s;
    logic [BUF_AW-1:0]   wr_idx_s, rd_idx_s;
    logic [PIX_W-1:0]    line_ram [0:2*LINE_PIX-1];
`ifdef CHRONI_LINE_FETCH_ATTR_EN
    logic [7:0]          attr_r, attr_s;
`endif

    function automatic logic [ADDR_W-1:0] font_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [7:0] code,
                                                    input logic [FS_W-1:0] scan);
        return base + (ADDR_W'(code) << FS_W) + ADDR_W'(scan);
    endfunction

`ifdef CHRONI_LINE_FETCH_ATTR_EN
    assign fg_cur_s = PIX_W'(attr_r[7:4]);
    assign bg_cur_s = PIX_W'(attr_r[3:0]);
`else
    assign fg_cur_s = fg_r;
    assign bg_cur_s = bg_r;
`endif
    // The back bank is always the one not being displayed
    assign wr_idx_s  = (front_r ? BUF_AW'(0) : LINE_PIX_B) + BUF_AW'({col_r, bit_r});
    assign wr_data_s = byte_r[3'd7 - bit_r] ? fg_cur_s : bg_cur_s;
    assign rd_idx_s  = (front_r ? LINE_PIX_B : BUF_AW'(0)) + BUF_AW'(pix_idx);

    // Next-state, memory handshake and line-RAM write control
    always_comb begin
        state_s = state_r;  req_s = req_r;    addr_s = addr_r;    col_s = col_r;
        bit_s = bit_r;      code_s = code_r;  byte_s = byte_r;    busy_s = busy_r;
        overrun_s = 1'b0;   front_s = front_r; wr_en_s = 1'b0;
`ifdef CHRONI_LINE_FETCH_ATTR_EN
        attr_s = attr_r;
`endif
        if (line_start) begin
            // An aborted build withdraws its request this edge and re-requests from CHAR
            overrun_s = busy_r;
            front_s   = ~front_r;
            state_s   = S_CHAR;
            req_s     = ~busy_r;
            addr_s    = text_addr;
            col_s     = '0;
            bit_s     = 3'd0;
            busy_s    = 1'b1;
        end else begin
            case (state_r)
                S_IDLE: begin
                    req_s = 1'b0;
                end
                S_CHAR: begin
                    if (!req_r) begin
                        req_s  = 1'b1;
                        addr_s = text_r + ADDR_W'(col_r);
                    end else if (mem_rd_ack) begin
                        code_s = mem_data;
`ifdef CHRONI_LINE_FETCH_ATTR_EN
                        state_s = S_ATTR;
                        addr_s  = text_r + ADDR_W'(col_r) + ATTR_OFFSET;
`else
                        state_s = S_FONT;
                        addr_s  = font_addr(font_r, mem_data, scan_r);
`endif
                    end else begin
                        req_s = 1'b1;
                    end
                end
`ifdef CHRONI_LINE_FETCH_ATTR_EN
                S_ATTR: begin
                    if (mem_rd_ack) begin
                        attr_s  = mem_data;
                        state_s = S_FONT;
                        addr_s  = font_addr(font_r, code_r, scan_r);
                    end else begin
                        req_s = 1'b1;
                    end
                end
`endif
                S_FONT: begin
                    if (mem_rd_ack) begin
                        byte_s  = mem_data;
                        req_s   = 1'b0;
                        state_s = S_SHIFT;
                        bit_s   = 3'd0;
                    end else begin
                        req_s = 1'b1;
                    end
                end
                S_SHIFT: begin
                    wr_en_s = 1'b1;
                    bit_s   = bit_r + 3'd1;
                    if (bit_r == 3'd7) begin
                        if (col_r == COL_LAST) begin
                            state_s = S_IDLE;
                            busy_s  = 1'b0;
                        end else begin
                            col_s   = col_r + COL_W'(1);
                            state_s = S_CHAR;
                            req_s   = 1'b1;
                            addr_s  = text_r + ADDR_W'(col_r) + ADDR_W'(1);
                        end
                    end else begin
                        state_s = S_SHIFT;
                    end
                end
                default: begin
                    state_s = S_IDLE;
                    req_s   = 1'b0;
                    busy_s  = 1'b0;
                end
            endcase
        end
    end

    // State and line-parameter registers
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            state_r <= S_IDLE;  req_r <= 1'b0;  addr_r <= '0;   col_r <= '0;
            bit_r <= 3'd0;      code_r <= 8'd0; byte_r <= 8'd0; busy_r <= 1'b0;
            overrun_r <= 1'b0;  front_r <= 1'b0;
            text_r <= '0;       font_r <= '0;   scan_r <= '0;   fg_r <= '0;  bg_r <= '0;
`ifdef CHRONI_LINE_FETCH_ATTR_EN
            attr_r <= 8'd0;
`endif
        end else begin
            state_r <= state_s; req_r <= req_s; addr_r <= addr_s; col_r <= col_s;
            bit_r <= bit_s;     code_r <= code_s; byte_r <= byte_s; busy_r <= busy_s;
            overrun_r <= overrun_s; front_r <= front_s;
`ifdef CHRONI_LINE_FETCH_ATTR_EN
            attr_r <= attr_s;
`endif
            if (line_start) begin
                text_r <= text_addr; font_r <= font_base; scan_r <= font_scan;
                fg_r <= fg_color;    bg_r <= bg_color;
            end
        end
    end

    // Line RAM write port (contents are not reset)
    always_ff @(posedge vga_clk) begin
        if (reset_n && wr_en_s) begin
            line_ram[wr_idx_s] <= wr_data_s;
        end
    end

    // Front-bank read; indices past the line show the latched background
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            pix_out <= '0;
        end else if ({1'b0, pix_idx} < LINE_PIX_I) begin
            pix_out <= line_ram[rd_idx_s];
        end else begin
            pix_out <= bg_r;
        end
    end

    assign mem_addr   = addr_r;
    assign mem_rd_req = req_r;
    assign busy       = busy_r;
    assign overrun    = overrun_r;
endmodule

// File: tb/tb_chroni_line_fetch.sv
// Scoreboard bench for chroni_line_fetch: a memory responder checks read addresses against
// an expected queue, and pixel reads are compared against a line model built from the same memory.
module tb_chroni_line_fetch;
    localparam int COLS = 40;
    localparam int LINE_PIX = COLS * 8;
`ifdef CHRONI_LINE_FETCH_ATTR_EN
    localparam int RD_PER_CHAR = 3;
`else
    localparam int RD_PER_CHAR = 2;
`endif

    logic        vga_clk = 1'b0, reset_n = 1'b0, line_start = 1'b0;
    logic [15:0] text_addr = 16'h0000, font_base = 16'h0000, mem_addr;
    logic [2:0]  font_scan = 3'd0;
    logic [7:0]  fg_color = 8'h00, bg_color = 8'h00, mem_data = 8'h00, pix_out;
    logic        mem_rd_req, mem_rd_ack = 1'b0, busy, overrun;
    logic [9:0]  pix_idx = 10'd0;

    chroni_line_fetch #(.COLS(COLS), .FONT_H(8), .PIX_W(8), .ADDR_W(16)) dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .line_start(line_start),
        .text_addr(text_addr), .font_base(font_base), .font_scan(font_scan),
        .fg_color(fg_color), .bg_color(bg_color), .mem_addr(mem_addr),
        .mem_rd_req(mem_rd_req), .mem_rd_ack(mem_rd_ack), .mem_data(mem_data),
        .pix_idx(pix_idx), .pix_out(pix_out), .busy(busy), .overrun(overrun)
    );

    always #5 vga_clk = ~vga_clk;

    int          n_checks = 0, n_fail = 0, cyc = 0, t_ls = 0, lat = 1, wait_cnt = 0;
    logic [7:0]  mem [0:65535];
    logic [15:0] held_addr;
    logic [15:0] addr_q [$];
    logic [7:0]  pix_q [$];

    always @(posedge vga_clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_pix(input logic [15:0] t, f, input logic [2:0] s,
                                           input logic [7:0] fg, bg, oor_bg, input int idx);
        logic [15:0] a;
        logic [7:0]  code, fb, fgc, bgc;
        int k;
        if (idx >= LINE_PIX) return oor_bg;
        k    = idx % 8;
        a    = t + 16'(idx / 8);
        code = mem[a];
        fb   = mem[16'(f + {8'h00, code} * 16'd8 + {13'd0, s})];
        fgc  = fg;
        bgc  = bg;
`ifdef CHRONI_LINE_FETCH_ATTR_EN
        fgc = {4'h0, mem[16'(a + 16'h0800)][7:4]};
        bgc = {4'h0, mem[16'(a + 16'h0800)][3:0]};
`endif
        return fb[7 - k] ? fgc : bgc;
    endfunction

    // Memory responder: acks `lat` cycles after a request appears, checks addresses
    initial begin
        forever begin
            @(posedge vga_clk); #1;
            if (mem_rd_ack) begin
                mem_rd_ack = 1'b0;
                wait_cnt = 0;
            end
            if (!mem_rd_req) begin
                wait_cnt = 0;
            end else begin
                if (wait_cnt == 0) held_addr = mem_addr;
                if (wait_cnt >= lat) begin
                    if (lat > 1) check_eq("addr_hold", {16'h0, mem_addr}, {16'h0, held_addr});
                    if (addr_q.size() > 0) check_eq("rd_addr", {16'h0, mem_addr}, {16'h0, addr_q.pop_front()});
                    mem_data   = mem[mem_addr];
                    mem_rd_ack = 1'b1;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    task automatic start_line(input logic [15:0] t, f, input logic [2:0] s,
                              input logic [7:0] fg, bg, input int nchk);
        logic [7:0] code;
        @(negedge vga_clk);
        text_addr = t; font_base = f; font_scan = s; fg_color = fg; bg_color = bg;
        line_start = 1'b1;
        addr_q.delete();
        for (int c = 0; c < nchk; c++) begin
            code = mem[16'(t + 16'(c))];
            addr_q.push_back(16'(t + 16'(c)));
`ifdef CHRONI_LINE_FETCH_ATTR_EN
            addr_q.push_back(16'(t + 16'(c) + 16'h0800));
`endif
            addr_q.push_back(16'(f + {8'h00, code} * 16'd8 + {13'd0, s}));
        end
        @(negedge vga_clk);
        line_start = 1'b0;
        t_ls = cyc;
    endtask

    task automatic wait_done(output int lt);
        while (busy && (cyc - t_ls) < 5000) @(negedge vga_clk);
        lt = cyc - t_ls;
    endtask

    task automatic read_pixels(input logic [15:0] t, f, input logic [2:0] s,
                               input logic [7:0] fg, bg, oor_bg, input int first, last);
        for (int i = first; i <= last + 1; i++) begin
            @(negedge vga_clk);
            if (i > first) check_eq($sformatf("pix%0d", i - 1), {24'h0, pix_out}, {24'h0, pix_q.pop_front()});
            if (i <= last) begin
                pix_idx = 10'(i);
                pix_q.push_back(exp_pix(t, f, s, fg, bg, oor_bg, i));
            end
        end
    endtask

    initial begin
        int lt, base;
        for (int a = 0; a < 65536; a++) mem[a] = 8'h41;
        mem[16'h020B] = 8'h3C;
        mem[16'h0213] = 8'h81;
        for (int c = 0; c < COLS; c++) begin
            mem[16'(16'h1000 + 16'(c))] = 8'h42;
            mem[16'(16'h0C01 + 16'(c))] = 8'h52;
        end
        base = COLS * (RD_PER_CHAR * 2 + 8);

        // Reset
        repeat (3) @(negedge vga_clk);
        check_eq("rst_req", {31'h0, mem_rd_req}, 32'h0);
        check_eq("rst_busy", {31'h0, busy}, 32'h0);
        check_eq("rst_overrun", {31'h0, overrun}, 32'h0);
        check_eq("rst_pix", {24'h0, pix_out}, 32'h0);
        check_eq("rst_addr", {16'h0, mem_addr}, 32'h0);
        reset_n = 1'b1;

        // Line A, single-cycle ack latency
        start_line(16'h0401, 16'h0000, 3'd3, 8'hAA, 8'h11, 2);
        check_eq("a_busy", {31'h0, busy}, 32'h1);
        wait_done(lt);
        check_eq("a_line_time", lt, base);
        start_line(16'h0401, 16'h0000, 3'd3, 8'hAA, 8'h11, 0);
        check_eq("b_no_overrun", {31'h0, overrun}, 32'h0);
        read_pixels(16'h0401, 16'h0000, 3'd3, 8'hAA, 8'h11, 8'h11, 0, LINE_PIX - 1);
        read_pixels(16'h0401, 16'h0000, 3'd3, 8'hAA, 8'h11, 8'h11, 1023, 1023);
        wait_done(lt);
        check_eq("b_done", {31'h0, busy}, 32'h0);

        // Line C, five-cycle ack latency
        lat = 5;
        start_line(16'h0401, 16'h0000, 3'd3, 8'hAA, 8'h11, 2);
        check_eq("c_no_overrun", {31'h0, overrun}, 32'h0);
        wait_done(lt);
        check_eq("c_line_time", lt, COLS * (RD_PER_CHAR * 6 + 8));
        lat = 1;

        // Line D aborted about 100 cycles in by line E
        start_line(16'h1000, 16'h0000, 3'd3, 8'hCC, 8'h44, 1);
        read_pixels(16'h0401, 16'h0000, 3'd3, 8'hAA, 8'h11, 8'h44, 0, 63);
        repeat (34) @(negedge vga_clk);
        start_line(16'h0401, 16'h0000, 3'd3, 8'h77, 8'h22, 2);
        check_eq("e_overrun", {31'h0, overrun}, 32'h1);
        check_eq("e_req_dropped", {31'h0, mem_rd_req}, 32'h0);
        @(negedge vga_clk);
        check_eq("e_overrun_pulse", {31'h0, overrun}, 32'h0);
        read_pixels(16'h1000, 16'h0000, 3'd3, 8'hCC, 8'h44, 8'h22, 0, 47);
        wait_done(lt);
        check_eq("e_line_time", {31'h0, (lt >= base && lt <= base + 1)}, 32'h1);
        start_line(16'h0401, 16'h0000, 3'd3, 8'h55, 8'h33, 0);
        check_eq("f_no_overrun", {31'h0, overrun}, 32'h0);
        read_pixels(16'h0401, 16'h0000, 3'd3, 8'h77, 8'h22, 8'h33, 0, LINE_PIX - 1);
        read_pixels(16'h0401, 16'h0000, 3'd3, 8'h77, 8'h22, 8'h33, 320, 321);
        wait_done(lt);

        // Address wrap at 0xFFFF
        start_line(16'hFFFF, 16'h0000, 3'd3, 8'hAA, 8'h11, 2);
        wait_done(lt);
        check_eq("g_line_time", lt, base);
        check_eq("addr_q_drained", addr_q.size(), 32'h0);

        // Reset mid-build
        start_line(16'h0401, 16'h0000, 3'd3, 8'hAA, 8'h11, 0);
        repeat (30) @(negedge vga_clk);
        reset_n = 1'b0;
        @(negedge vga_clk);
        check_eq("mrst_busy", {31'h0, busy}, 32'h0);
        check_eq("mrst_req", {31'h0, mem_rd_req}, 32'h0);
        check_eq("mrst_pix", {24'h0, pix_out}, 32'h0);
        reset_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
